keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Upstream stage of the note-memory game. Scans a 4x4 active-low key matrix, synchronises and debounces the row returns, and produces one clean note code per press. The code feeds the game's keypad_input port, and key_strobe feeds keypad_enable. One strobe per physical press, with no bounce artefacts, so each press is counted as exactly one answer.

Parameters:
SCAN_DIV, 50000, clk cycles each column is driven (1 ms at 50 MHz); legal range 4 or more.
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a new stable state; legal range 1 to 15.
REPEAT_SCANS, 250, full scans between auto-repeat strobes; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
row_in  in  4  matrix rows, active-low, externally pulled up, asynchronous to clk
col_out  out  4  column drive, active-low one-hot
key_code  out  4  note code of the last accepted key
key_strobe  out  1  one-cycle pulse on an accepted press
key_release  out  1  one-cycle pulse on an accepted release
key_held  out  1  level, high while an accepted key is pressed
multi_key  out  1  level, high while the stable scan result is two or more keys

Behaviour:
- Reset values: col_out=4'b1110, key_code=0, key_strobe=0, key_release=0, key_held=0, multi_key=0. All counters, the candidate result and the stable result are cleared to NONE.
- row_in passes through a 2-flop synchroniser before use.
- Column walk: column c is driven low for SCAN_DIV cycles, then c advances 0 -> 1 -> 2 -> 3 -> 0.
- Rows are sampled on the last cycle of each column window. This allows settle time plus the 2-flop latency.
- Full scan = 4*SCAN_DIV cycles. At the end of column 3 the scan result is classified:
  - NONE: no low row seen.
  - KEY(code): exactly one low (row, col) in the whole scan.
  - MULTI: more than one.
- Key map: code = (4*row + col + 1) mod 16.
  - Row 0 = 1, 2, 3, 4; row 1 = 5, 6, 7, 8; row 2 = 9 to 12; row 3 = 13, 14, 15, 0.
  - Notes 1 to 8 are rows 0 and 1.
- Debounce: a scan result equal to the candidate increments stable_cnt (saturating). A differing result becomes the new candidate with stable_cnt=1. When stable_cnt reaches DEBOUNCE_SCANS and candidate differs from stable, stable is updated. Acceptance latency is therefore DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 full scans after the contact settles.
- Stable-state transitions:
  - NONE -> KEY(k): key_code<=k, key_held<=1, key_strobe pulses in the update cycle.
  - KEY -> NONE: key_held<=0, key_release pulses; key_code keeps its value.
  - KEY(a) -> KEY(b): key_release pulses in the update cycle. The next cycle sets key_code=b and pulses key_strobe. key_held stays 1.
  - Any -> MULTI: multi_key<=1. If a key was held, key_release pulses and key_held<=0. No strobe is ever issued while MULTI.
  - MULTI -> other: multi_key<=0, then follow the rules above as if the previous state were NONE.
- key_strobe and key_release are never high in the same cycle.
- Reset mid-press: all outputs return to their reset values immediately. A key still held after reset is a fresh press and strobes again after debounce.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: while stable is KEY, key_strobe re-pulses every REPEAT_SCANS full scans after the initial strobe, with the same key_code. The repeat counter clears on any stable change.
- Undefined: exactly one strobe per press. The repeat counter and logic are absent; REPEAT_SCANS is ignored.

Decomposition:
- keypad_pkg:
  - scan result enum (NONE, KEY, MULTI);
  - NUM_ROWS=4, NUM_COLS=4;
  - key-map function (row, col) -> code.
- Sub-module keypad_debounce: generic candidate/stable_cnt/stable tracker on a result vector with an update-valid input. Instantiated once here; the scanner keeps the column walk, synchroniser, classification and output pulse logic.

Test Plan:
- Use SCAN_DIV=4, DEBOUNCE_SCANS=3, so a full scan is 16 cycles.
- Reset, no keys -> col_out cycles 1110, 1101, 1011, 0111 every 4 cycles; all other outputs stay 0.
- Hold row1/col2 steady -> exactly one key_strobe within 48 to 64 cycles; key_code=7, key_held=1. No further strobes over 500 cycles.
- Row1/col2 contact toggling every 5 cycles for 60 cycles, then steady -> exactly one key_strobe, with key_code=7.
- Release after press -> key_release one pulse within 48 to 64 cycles; key_held=0, key_code stays 7.
- Row0/col0 and row3/col3 pressed together -> multi_key=1, no key_strobe. Then release row3/col3 only -> multi_key=0, then key_strobe with key_code=1.
- Assert reset for 3 cycles mid-press -> key_held=0 immediately; a new key_strobe follows after debounce while the key is still pressed. With the macro defined, strobes then repeat every REPEAT_SCANS scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad scanner: matrix dimensions, the
//   per-scan classification (NONE / KEY / MULTI) and the (row, col) -> note
//   code map.
//   The all-zero encoding of scan_res_t is NONE with code 0. The debounce
//   tracker relies on this: its cleared state is zero.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e  kind;
    logic [3:0]  code;
  } scan_res_t;

  localparam int RES_W = $bits(scan_res_t);

  // code = (4*row + col + 1) mod 16; {row, col} is exactly 4*row + col, and
  // the 4-bit add wraps row3/col3 around to 0.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    return {row, col} + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Generic candidate / stable tracker for a W-bit result that is offered
//   once per update strobe. A result equal to the candidate raises a
//   saturating count; a different result becomes the new candidate with a
//   count of 1. Once the count reaches DEBOUNCE_SCANS and the candidate
//   differs from the stable value, the stable value takes the candidate.
//   All state clears to zero.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-high
//   upd_i     in   a new result is present on result_i this cycle
//   result_i  in   W-bit result
//   stable_o  out  accepted stable result
//   chg_o     out  one-cycle pulse, high in the first cycle stable_o shows a new value
module keypad_debounce #(
  parameter int W              = 6,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         upd_i,
  input  logic [W-1:0] result_i,
  output logic [W-1:0] stable_o,
  output logic         chg_o
);

  logic [W-1:0] cand_q, cand_d;
  logic [W-1:0] stable_q, stable_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         chg_q, chg_d;

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_d    = 1'b0;
    if (upd_i) begin
      if (result_i == cand_q) begin
        if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = result_i;
        cnt_d  = 4'd1;
      end
      if ((cnt_d >= 4'(DEBOUNCE_SCANS)) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        chg_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= 4'd0;
      chg_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  assign stable_o = stable_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low key matrix, synchronises the row returns,
//   classifies each full scan as NONE / KEY(code) / MULTI, debounces the
//   result and turns stable-state changes into clean press/release pulses.
//   Optional build macro KEYPAD_AUTOREPEAT_EN: while a key stays accepted,
//   key_strobe re-pulses every REPEAT_SCANS full scans.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   row_in[3:0]  in   matrix rows, active-low, asynchronous to clk
//   col_out[3:0] out  column drive, active-low one-hot
//   key_code     out  note code of the last accepted key
//   key_strobe   out  one-cycle pulse on an accepted press
//   key_release  out  one-cycle pulse on an accepted release
//   key_held     out  high while an accepted key is pressed
//   multi_key    out  high while the stable result is two or more keys
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       key_release,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
  begin : g_bad_param
    $error("keypad_scanner: parameter out of legal range");
  end

  // Row synchroniser; rows idle high (pulled up).
  logic [3:0] row_s1_q, row_s2_q;

  // Column walk and per-scan hit accumulation.
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;   // 0, 1 or 2 (= two or more)
  logic [3:0]       hit_code_q, hit_code_d;

  logic       last_in_col, scan_end;
  logic [2:0] col_hits, tot;
  logic [3:0] col_code, code_sel;
  scan_res_t  scan_res;

  // Debounced result.
  logic [RES_W-1:0] stable_vec;
  scan_res_t        stable;
  logic             chg;

  // Output registers.
  logic       strobe_q, strobe_d;
  logic       release_q, release_d;
  logic       held_q, held_d;
  logic       multi_q, multi_d;
  logic [3:0] code_q, code_d;
  logic       pend_q, pend_d;               // strobe owed after a key-to-key change
  logic [3:0] pend_code_q, pend_code_d;

  assign col_out     = ~(4'b0001 << col_q);
  assign last_in_col = (div_q == DIV_W'(SCAN_DIV - 1));
  assign scan_end    = last_in_col && (col_q == 2'd3);

  always_comb begin
    col_hits = 3'd0;
    col_code = 4'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(2'(r), col_q);
      end
    end
    tot = {1'b0, hit_cnt_q} + col_hits;
    // With exactly one hit in total it came either from an earlier column or
    // from this one.
    code_sel = (hit_cnt_q == 2'd1) ? hit_code_q : col_code;

    scan_res.kind = RES_NONE;
    scan_res.code = 4'd0;
    if (tot == 3'd1) begin
      scan_res.kind = RES_KEY;
      scan_res.code = code_sel;
    end else if (tot >= 3'd2) begin
      scan_res.kind = RES_MULTI;
    end
  end

  always_comb begin
    div_d      = div_q + DIV_W'(1);
    col_d      = col_q;
    hit_cnt_d  = hit_cnt_q;
    hit_code_d = hit_code_q;
    if (last_in_col) begin
      div_d = '0;
      col_d = col_q + 2'd1;
      if (scan_end) begin
        hit_cnt_d  = 2'd0;
        hit_code_d = 4'd0;
      end else begin
        hit_cnt_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        if (tot == 3'd1) hit_code_d = code_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      div_q      <= '0;
      col_q      <= 2'd0;
      hit_cnt_q  <= 2'd0;
      hit_code_q <= 4'd0;
    end else begin
      row_s1_q   <= row_in;
      row_s2_q   <= row_s1_q;
      div_q      <= div_d;
      col_q      <= col_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_code_q <= hit_code_d;
    end
  end

  keypad_debounce #(
    .W              (RES_W),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .upd_i    (scan_end),
    .result_i (scan_res),
    .stable_o (stable_vec),
    .chg_o    (chg)
  );

  assign stable = stable_vec;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_fire;

  // chg follows scan_end by one cycle and pend_q by two, so a repeat strobe
  // never lands on a release or an owed strobe.
  assign rep_fire = scan_end && held_q && !pend_q && (rep_cnt_q == 16'(REPEAT_SCANS - 1));

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (chg) begin
      rep_cnt_d = 16'd0;
    end else if (scan_end && held_q) begin
      rep_cnt_d = rep_fire ? 16'd0 : rep_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_cnt_q <= 16'd0;
    else       rep_cnt_q <= rep_cnt_d;
  end
`else
  logic rep_fire;
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    strobe_d    = 1'b0;
    release_d   = 1'b0;
    held_d      = held_q;
    multi_d     = multi_q;
    code_d      = code_q;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    if (pend_q) begin
      code_d   = pend_code_q;
      strobe_d = 1'b1;
    end
    if (chg) begin
      case (stable.kind)
        RES_KEY: begin
          multi_d = 1'b0;
          if (held_q) begin
            // Key-to-key: release now, strobe the new code next cycle.
            release_d   = 1'b1;
            pend_d      = 1'b1;
            pend_code_d = stable.code;
          end else begin
            code_d   = stable.code;
            held_d   = 1'b1;
            strobe_d = 1'b1;
          end
        end
        RES_MULTI: begin
          multi_d = 1'b1;
          if (held_q) begin
            release_d = 1'b1;
            held_d    = 1'b0;
          end
        end
        default: begin
          multi_d = 1'b0;
          if (held_q) begin
            release_d = 1'b1;
            held_d    = 1'b0;
          end
        end
      endcase
    end else if (rep_fire) begin
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q    <= 1'b0;
      release_q   <= 1'b0;
      held_q      <= 1'b0;
      multi_q     <= 1'b0;
      code_q      <= 4'd0;
      pend_q      <= 1'b0;
      pend_code_q <= 4'd0;
    end else begin
      strobe_q    <= strobe_d;
      release_q   <= release_d;
      held_q      <= held_d;
      multi_q     <= multi_d;
      code_q      <= code_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
    end
  end

  assign key_strobe  = strobe_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;
  assign key_code    = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_strobe, key_release, key_held, multi_key;

  logic [15:0] keys;   // keys[4*row + col] = 1 while that contact is closed

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int release_cnt = 0;
  int overlap_cnt = 0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .key_release (key_release),
    .key_held    (key_held),
    .multi_key   (multi_key)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a closed key sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk) begin
    if (key_strobe)  strobe_cnt  <= strobe_cnt + 1;
    if (key_release) release_cnt <= release_cnt + 1;
    if (key_strobe && key_release) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Return at the negedge of the first cycle of column 0.
  task automatic align_scan();
    logic [3:0] prev;
    prev = col_out;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_out == 4'b1110) return;
      prev = col_out;
    end
    checks++;
    errors++;
    $display("FAIL align_scan: col_out=%b, required wrap 0111->1110", col_out);
  endtask

  // n = cycles until the pulse is seen at a negedge, -1 on timeout.
  task automatic wait_pulse(input bit rel, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if ((rel ? key_release : key_strobe) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;
    keys  = 16'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL rst_col: got %b, required 1110", col_out); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rst_code: got %0d, required 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b, required 0", key_held); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL rst_multi: got %b, required 0", multi_key); end
    checks++; if ({key_strobe, key_release} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b, required 00", {key_strobe, key_release}); end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (col_out !== exp_col[k]) begin errors++; $display("FAIL col_walk[%0d]: got %b, required %b", k, col_out, exp_col[k]); end
      repeat (4) @(negedge clk);
    end
    repeat (48) @(negedge clk);
    checks++;
    if (strobe_cnt !== 0 || release_cnt !== 0 || key_held !== 1'b0 || multi_key !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: strobes=%0d releases=%0d held=%b multi=%b, required all 0", strobe_cnt, release_cnt, key_held, multi_key);
    end
  endtask

  task automatic test_single_press();
    int n, s0;
    align_scan();
    s0 = strobe_cnt;
    keys[6] = 1'b1;                  // row1 / col2 -> note 7
    wait_pulse(1'b0, 80, n);
    checks++; if (n < 48 || n > 64) begin errors++; $display("FAIL press_latency: got %0d cycles, required 48..64", n); end
    checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL press_code: got %0d, required 7", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b, required 1", key_held); end
    @(negedge clk);
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL press_pulse_width: strobe got %b one cycle later, required 0", key_strobe); end
    repeat (500) @(negedge clk);
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL press_single: got %0d strobes, required 1", strobe_cnt - s0); end
  endtask

  task automatic test_release();
    int n, r0;
    align_scan();
    r0 = release_cnt;
    keys[6] = 1'b0;
    wait_pulse(1'b1, 80, n);
    checks++; if (n < 48 || n > 64) begin errors++; $display("FAIL release_latency: got %0d cycles, required 48..64", n); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b, required 0", key_held); end
    checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL release_code: got %0d, required 7", key_code); end
    repeat (100) @(negedge clk);
    checks++; if (release_cnt !== r0 + 1) begin errors++; $display("FAIL release_single: got %0d releases, required 1", release_cnt - r0); end
  endtask

  task automatic test_bounce();
    int n, s0;
    align_scan();
    s0 = strobe_cnt;
    for (int i = 0; i < 12; i++) begin
      keys[6] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    keys[6] = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL bounce_strobes: got %0d, required 1", strobe_cnt - s0); end
    checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL bounce_code: got %0d, required 7", key_code); end
    keys[6] = 1'b0;
    wait_pulse(1'b1, 100, n);
    checks++; if (n < 0) begin errors++; $display("FAIL bounce_release: got no release within 100 cycles, required one"); end
  endtask

  task automatic test_multi();
    int n, s0;
    repeat (20) @(negedge clk);
    align_scan();
    s0 = strobe_cnt;
    keys[0]  = 1'b1;                 // row0 / col0 -> note 1
    keys[15] = 1'b1;                 // row3 / col3 -> note 0
    repeat (70) @(negedge clk);
    checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_set: got %b, required 1", multi_key); end
    checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL multi_no_strobe: got %0d strobes, required 0", strobe_cnt - s0); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b, required 0", key_held); end
    align_scan();
    keys[15] = 1'b0;
    wait_pulse(1'b0, 80, n);
    checks++; if (n < 0) begin errors++; $display("FAIL multi_to_key_strobe: got none within 80 cycles, required one"); end
    checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b, required 0", multi_key); end
    checks++; if (key_code !== 4'd1) begin errors++; $display("FAIL multi_to_key_code: got %0d, required 1", key_code); end
  endtask

  task automatic test_reset_midpress();
    int n, s0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b, required 0", key_held); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d, required 0", key_code); end
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b, required 1110", col_out); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    wait_pulse(1'b0, 80, n);
    checks++; if (n < 48 || n > 64) begin errors++; $display("FAIL midrst_restrobe: got %0d cycles, required 48..64", n); end
    checks++; if (key_code !== 4'd1) begin errors++; $display("FAIL midrst_code_after: got %0d, required 1", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL midrst_held_after: got %b, required 1", key_held); end
    repeat (2) @(negedge clk);
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL midrst_count: got %0d strobes, required 1", strobe_cnt - s0); end
  endtask

  initial begin
    keys  = 16'h0;
    reset = 1'b1;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_multi();
    test_reset_midpress();
    keys = 16'h0;
    repeat (80) @(negedge clk);
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_release_overlap: got %0d cycles, required 0", overlap_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
